sync_fifo: RTL and testbench

// - Single-clock synchronous FIFO: buffers width-bit words between a producer and a consumer on the same clock.
// - Reports full/empty status and a registered read-data output.
// - Exposes internal cnt, wr_ptr and rd_ptr by these exact names so a bound assertion module can observe them hierarchically.

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/sync_fifo_mem.sv | 35 +++
 rtl/sync_fifo.sv | 69 ++++++
 tb/tb_sync_fifo.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the single-clock FIFO and its storage array.
package sync_fifo_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    // Pointer width for an arbitrary power-of-two depth.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register array with one write port and one registered read port.
// Read data appears one cycle after rd_en and holds when rd_en is low.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int width = FIFO_WIDTH,
    parameter int depth = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ptr_bits(depth)-1:0] wr_addr,
    input  logic [width-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic [ptr_bits(depth)-1:0] rd_addr,
    output logic [width-1:0]           rd_data
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO; read data registered, valid one cycle after an accepted read.
// Writes while full are dropped unless a read frees a slot in the same cycle.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int width = FIFO_WIDTH,
    parameter int depth = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [width-1:0] fifo_data_in,
    input  logic             fifo_write,
    input  logic             fifo_read,
    output logic [width-1:0] fifo_data_out,
    output logic             fifo_full,
    output logic             fifo_empty
);

    localparam int AW = ptr_bits(depth);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(depth);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          wr_en;
    logic          rd_en;

    assign fifo_full  = (cnt == DEPTH_CNT);
    assign fifo_empty = (cnt == '0);

    // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign rd_en = fifo_read & ~fifo_empty;
    assign wr_en = fifo_write & (~fifo_full | rd_en);

    always_ff @(posedge clk) begin
        if (rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    sync_fifo_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk     (clk),
        .rst     (rst_),
        .wr_en   (wr_en & ~rst_),
        .wr_addr (wr_ptr),
        .wr_data (fifo_data_in),
        .rd_en   (rd_en & ~rst_),
        .rd_addr (rd_ptr),
        .rd_data (fifo_data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and random stimulus against a queue-based FIFO model.
module tb_sync_fifo;

    localparam int W = 16;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst_;
    logic [W-1:0] fifo_data_in;
    logic         fifo_write;
    logic         fifo_read;
    logic [W-1:0] fifo_data_out;
    logic         fifo_full;
    logic         fifo_empty;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model_q[$];
    logic [W-1:0] exp_dout;
    int           writes_done;
    int           reads_done;

    sync_fifo #(.width(W), .depth(D)) dut (
        .clk           (clk),
        .rst_          (rst_),
        .fifo_data_in  (fifo_data_in),
        .fifo_write    (fifo_write),
        .fifo_read     (fifo_read),
        .fifo_data_out (fifo_data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"},   32'(fifo_data_out), 32'(exp_dout));
        chk({tag, ".full"},   32'(fifo_full),     32'(model_q.size() == D));
        chk({tag, ".empty"},  32'(fifo_empty),    32'(model_q.size() == 0));
        chk({tag, ".cnt"},    32'(dut.cnt),       32'(model_q.size()));
        chk({tag, ".wr_ptr"}, 32'(dut.wr_ptr),    32'(writes_done % D));
        chk({tag, ".rd_ptr"}, 32'(dut.rd_ptr),    32'(reads_done % D));
    endtask

    // One clock: inputs driven at negedge, model advanced, outputs sampled 1ns after posedge.
    task automatic step(input logic rst, input logic wr, input logic rd,
                        input logic [W-1:0] din, input string tag);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        rst_         = rst;
        fifo_write   = wr;
        fifo_read    = rd;
        fifo_data_in = din;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            exp_dout    = '0;
            writes_done = 0;
            reads_done  = 0;
        end else begin
            rd_ok = rd && (model_q.size() > 0);
            wr_ok = wr && ((model_q.size() < D) || rd_ok);
            if (rd_ok) begin
                exp_dout = model_q.pop_front();
                reads_done++;
            end
            if (wr_ok) begin
                model_q.push_back(din);
                writes_done++;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_ = 1'b1; fifo_write = 1'b0; fifo_read = 1'b0; fifo_data_in = '0;
        exp_dout = '0; writes_done = 0; reads_done = 0;

        step(1, 0, 0, 0, "reset");
        step(1, 0, 0, 0, "reset");

        for (int i = 0; i < D; i++) step(0, 1, 0, 16'd7, "fill");
        step(0, 1, 0, 16'h0bad, "fill_drop");
        chk("fill_drop.cnt_is_depth", 32'(dut.cnt), 32'(D));
        chk("fill_drop.wr_ptr_zero",  32'(dut.wr_ptr), 32'd0);

        step(1, 0, 0, 0, "reset2");
        for (int i = 1; i <= D; i++) step(0, 1, 0, W'(i), "drain_wr");
        for (int i = 1; i <= D; i++) begin
            step(0, 0, 1, 0, "drain_rd");
            chk("drain_order", 32'(fifo_data_out), 32'(i));
        end
        step(0, 0, 1, 0, "read_empty");
        chk("read_empty.hold", 32'(fifo_data_out), 32'd16);

        for (int i = 0; i < D; i++) step(0, 1, 0, W'(16'h100 + i), "refill");
        step(0, 1, 1, 16'h0abc, "rw_full");
        chk("rw_full.oldest_out", 32'(fifo_data_out), 32'h100);
        chk("rw_full.cnt",        32'(dut.cnt), 32'(D));

        step(1, 0, 0, 0, "reset3");
        step(0, 1, 1, 16'h0055, "rw_empty");
        chk("rw_empty.cnt", 32'(dut.cnt), 32'd1);
        step(0, 0, 1, 0, "rw_empty_rd");
        chk("rw_empty.no_fallthrough", 32'(fifo_data_out), 32'h55);

        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, W'(16'h200 + i), "wrap_wr");
            step(0, 0, 1, 0, "wrap_rd");
            chk("wrap.order", 32'(fifo_data_out), 32'(16'h200 + i));
        end
        for (int i = 0; i < 5; i++) step(0, 1, 0, W'(i), "mid_wr");
        step(1, 1, 1, 16'hffff, "mid_reset");
        chk("mid_reset.empty", 32'(fifo_empty), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 45), W'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
